// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared definitions for the MIPS multiply/divide unit.
//   op_e        - decoder-supplied 3-bit operation encoding
//   state_e     - sequencer states (IDLE, RUN, SIGN, DONE)
//   MULDIV_ITER - number of iterations of the shift-add / restoring-divide loop
//   abs32       - two's-complement magnitude helper
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int MULDIV_ITER = 32;
    localparam logic [4:0] CNT_LAST = 5'(MULDIV_ITER - 1);

    // Magnitude of a two's-complement word; 0x8000_0000 maps to itself,
    // which is exactly the unsigned magnitude the datapath needs.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        if (v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/mips_cpu_div_step.sv
// mips_cpu_div_step: one combinational restoring-divide iteration.
//   rem_in  - partial remainder (always < divisor on entry unless divisor = 0)
//   bit_in  - next dividend bit shifted into the remainder
//   divisor - unsigned divisor magnitude
//   rem_out - next partial remainder
//   q_out   - quotient bit produced by this iteration
module mips_cpu_div_step (
    input  logic [31:0] rem_in,
    input  logic        bit_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_out
);

    logic [32:0] shifted_s;
    logic [32:0] diff_s;

    // Trial subtraction; keep the difference only when it does not underflow.
    always_comb begin
        shifted_s = {rem_in, bit_in};
        diff_s    = shifted_s - {1'b0, divisor};
        if (shifted_s >= {1'b0, divisor}) begin
            rem_out = diff_s[31:0];
            q_out   = 1'b1;
        end else begin
            rem_out = shifted_s[31:0];
            q_out   = 1'b0;
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative HI/LO multiply/divide unit for a MIPS core.
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   start  - request strobe, accepted only while idle (IDLE/DONE)
//   op     - MULT/MULTU/DIV/DIVU/MTHI/MTLO (110/111 ignored)
//   a, b   - rs / rt operands
//   busy   - high while an iterative operation is in flight
//   done   - one-cycle completion pulse
//   hi, lo - architectural HI/LO registers
// Optional feature: define MIPS_CPU_MULDIV_FAST_MULT_EN for a one-cycle
// 64-bit multiplier; divides keep the 32-iteration path.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_r, state_nxt_s;
    logic [4:0]  cnt_r;
    // Multiply: {upper partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [63:0] prod_r;
    logic [31:0] opnd_r;
    logic        is_div_r, neg_q_r, neg_r_r;
    logic [31:0] hi_r, lo_r;
    logic        busy_r, done_r;

    logic        load_s, mthi_s, mtlo_s, fast_s, busy_nxt_s, signed_s;
    logic [31:0] abs_a_s, abs_b_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_nxt_s, div_nxt_s;
    logic [31:0] div_rem_s;
    logic        div_q_s;
    logic [31:0] res_hi_s, res_lo_s;

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Next-state decode and one-shot control strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        mthi_s      = 1'b0;
        mtlo_s      = 1'b0;
        fast_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                state_nxt_s = ST_IDLE;
                if (start) begin
                    case (op_e'(op))
                        OP_MULT, OP_MULTU: begin
                            load_s = 1'b1;
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                            fast_s      = 1'b1;
                            state_nxt_s = ST_SIGN;
`else
                            state_nxt_s = ST_RUN;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            load_s      = 1'b1;
                            state_nxt_s = ST_RUN;
                        end
                        OP_MTHI: begin
                            mthi_s      = 1'b1;
                            state_nxt_s = ST_DONE;
                        end
                        OP_MTLO: begin
                            mtlo_s      = 1'b1;
                            state_nxt_s = ST_DONE;
                        end
                        default: state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_SIGN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SIGN: state_nxt_s = ST_DONE;
            default: state_nxt_s = ST_IDLE;
        endcase
        // The single-cycle multiply passes through SIGN without raising busy.
        busy_nxt_s = (state_nxt_s == ST_RUN) || ((state_nxt_s == ST_SIGN) && !fast_s);
    end

    // Operand magnitudes and one shift-add step.
    always_comb begin
        signed_s  = (op == OP_MULT) || (op == OP_DIV);
        abs_a_s   = signed_s ? abs32(a) : a;
        abs_b_s   = signed_s ? abs32(b) : b;
        mul_sum_s = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, opnd_r} : 33'd0);
        mul_nxt_s = {mul_sum_s, prod_r[31:1]};
        div_nxt_s = {div_rem_s, prod_r[30:0], div_q_s};
    end

    mips_cpu_div_step u_div_step (
        .rem_in  (prod_r[63:32]),
        .bit_in  (prod_r[31]),
        .divisor (opnd_r),
        .rem_out (div_rem_s),
        .q_out   (div_q_s)
    );

    // Sign correction of the finished magnitude result.
    always_comb begin
        res_hi_s = prod_r[63:32];
        res_lo_s = prod_r[31:0];
        if (is_div_r) begin
            // With a zero divisor the remainder ends up as |a|, so the
            // normal sign fix-up already yields hi = a.
            if (neg_r_r) begin
                res_hi_s = 32'd0 - prod_r[63:32];
            end else begin
                res_hi_s = prod_r[63:32];
            end
            if (opnd_r == 32'd0) begin
                res_lo_s = DIV0_LO;
            end else if (neg_q_r) begin
                res_lo_s = 32'd0 - prod_r[31:0];
            end else begin
                res_lo_s = prod_r[31:0];
            end
        end else begin
            if (neg_q_r) begin
                {res_hi_s, res_lo_s} = 64'd0 - prod_r;
            end else begin
                {res_hi_s, res_lo_s} = prod_r;
            end
        end
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r    <= 5'd0;
            prod_r   <= 64'd0;
            opnd_r   <= 32'd0;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
        end else if (load_s) begin
            cnt_r    <= 5'd0;
            is_div_r <= op[1];
            neg_q_r  <= signed_s && (a[31] ^ b[31]);
            neg_r_r  <= signed_s && a[31];
            if (op[1]) begin
                prod_r <= {32'd0, abs_a_s};
                opnd_r <= abs_b_s;
            end else begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                prod_r <= {32'd0, abs_a_s} * {32'd0, abs_b_s};
                opnd_r <= abs_b_s;
`else
                prod_r <= {32'd0, abs_b_s};
                opnd_r <= abs_a_s;
`endif
            end
        end else if (state_r == ST_RUN) begin
            cnt_r  <= cnt_r + 5'd1;
            prod_r <= is_div_r ? div_nxt_s : mul_nxt_s;
        end
    end

    // Architectural HI/LO: written only by SIGN or by MTHI/MTLO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (state_r == ST_SIGN) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (mthi_s) begin
            hi_r <= a;
        end else if (mtlo_s) begin
            lo_r <= a;
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: directed self-checking bench for mips_cpu_muldiv.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_mips_cpu_muldiv;

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    localparam int   MUL_LAT  = 2;
    localparam logic MUL_BUSY = 1'b0;
`else
    localparam int   MUL_LAT  = 34;
    localparam logic MUL_BUSY = 1'b1;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int lat;
    int done_cnt;
    logic busy_first;

    mips_cpu_muldiv #(.DIV0_LO(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge (E0); returns with lat = 1 at the
    // falling edge after E0, operand inputs scrambled to prove latching.
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0000;
        busy_first = busy;
    endtask

    task automatic step();
        @(posedge clk);
        lat++;
        @(negedge clk);
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && lat < 100) step();
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                       input int elat, input logic ebusy);
        launch(o, x, y);
        check({tag, ".busy"}, 32'(busy_first), 32'(ebusy));
        wait_done();
        check({tag, ".lat"}, 32'(lat), 32'(elat));
        check({tag, ".hi"}, hi, eh);
        check({tag, ".lo"}, lo, el);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        check("rst.hi", hi, 32'h0);
        check("rst.lo", lo, 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.done", 32'(done), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        run("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, MUL_BUSY);
        run("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, MUL_BUSY);
        run("mult_min",  3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT, MUL_BUSY);
        run("div_neg",   3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b1);
        run("div_negb",  3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 1'b1);
        run("divu",      3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        34, 1'b1);
        run("div_wrap",  3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 1'b1);
        run("divu_zero", 3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 34, 1'b1);
        run("div_zero",  3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 34, 1'b1);

        // Results hold while idle.
        repeat (5) @(negedge clk);
        check("hold.hi", hi, 32'hFFFF_FFF9);
        check("hold.lo", lo, 32'hFFFF_FFFF);
        check("hold.done", 32'(done), 32'h0);

        // MTHI presented while a divide is running must be ignored.
        launch(3'b011, 32'd100, 32'd7);
        repeat (8) step();
        start = 1'b1; op = 3'b100; a = 32'h0000_AAAA;
        step();
        start = 1'b0;
        check("busy_mthi.hi", hi, 32'hFFFF_FFF9);
        check("busy_mthi.busy", 32'(busy), 32'h1);
        wait_done();
        check("busy_mthi.lat", 32'(lat), 32'd34);
        check("busy_mthi.rhi", hi, 32'd2);
        check("busy_mthi.rlo", lo, 32'd14);

        run("mthi", 3'b100, 32'h0000_AAAA, 32'h0, 32'h0000_AAAA, 32'd14, 1, 1'b0);
        run("mtlo", 3'b101, 32'h0000_5555, 32'h0, 32'h0000_AAAA, 32'h0000_5555, 1, 1'b0);

        // Reserved op: nothing happens.
        launch(3'b110, 32'h1111_1111, 32'h2222_2222);
        check("rsvd.busy", 32'(busy_first), 32'h0);
        check("rsvd.done", 32'(done), 32'h0);
        step();
        check("rsvd.done2", 32'(done), 32'h0);
        check("rsvd.hi", hi, 32'h0000_AAAA);
        check("rsvd.lo", lo, 32'h0000_5555);

        // Reset in the middle of a divide aborts it.
        launch(3'b010, 32'd100, 32'd7);
        repeat (14) step();
        check("abort.busy_pre", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("abort.hi", hi, 32'h0);
        check("abort.lo", lo, 32'h0);
        check("abort.busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort.no_done", 32'(done_cnt), 32'h0);
        check("abort.hi_post", hi, 32'h0);
        check("abort.lo_post", lo, 32'h0);
        check("abort.busy_post", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 SHALL have parameter DIV0_LO, default 32'hFFFF_FFFF, the LO value written on divide-by-zero.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port start, input, 1 bit: request strobe, sampled only when busy=0.
REQ-005 SHALL have port op, input, 3 bits, decoder-supplied: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-006 SHALL have port a, input, 32 bits: rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-007 SHALL have port b, input, 32 bits: rt operand (divisor / multiplier).
REQ-008 SHALL have port busy, output, 1 bit: high in RUN and SIGN states.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse, high in DONE state.
REQ-010 SHALL have ports hi and lo, outputs, 32 bits each: architectural HI/LO registers, read by the writeback path for MFHI/MFLO.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, SIGN, DONE.
REQ-012 IDLE/DONE with start=1 and op in {000..011}: latch |a|,|b| (signed ops) or a,b (unsigned ops) plus result signs; clear counter; go to RUN.
REQ-013 RUN: one shift-add (MULT/MULTU) or one restoring-divide (DIV/DIVU) iteration per cycle for exactly 32 cycles, counter 0..31, then go to SIGN.
REQ-014 SIGN: apply sign correction and write hi/lo in the same edge; go to DONE. MULT: negate 64-bit product if a[31]^b[31]. DIV: quotient negated if a[31]^b[31], remainder takes sign of a.
REQ-015 DONE: done=1 for one cycle; hi/lo already hold the new result; next state IDLE, or RUN if a new start is accepted.
REQ-016 Iterative latency: start sampled at edge E0, busy=1 from E1 through E33, done=1 in the cycle after E33 (34 cycles total).
REQ-017 MTHI/MTLO with start=1 and busy=0: write hi (resp. lo) with a at that edge; go to DONE; the other register is unchanged.
REQ-018 A divide with b=0: hi=a, lo=DIV0_LO; latency identical to any other divide; no exception raised.
REQ-019 start while busy=1 SHALL be ignored, with no effect on state or operands.
REQ-020 Reserved op with start=1 SHALL be ignored; FSM stays in its current idle state.
REQ-021 hi/lo SHALL change only in SIGN, on MTHI/MTLO, or on reset; they hold their value between operations.
REQ-022 MULT of 0x8000_0000 by 0x8000_0000 SHALL give hi=0x4000_0000, lo=0; DIV of 0x8000_0000 by 0xFFFF_FFFF SHALL give lo=0x8000_0000, hi=0 (wraps, no trap).

Reset
REQ-023 reset=0 SHALL asynchronously force state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and clear internal accumulators.
REQ-024 reset asserted mid-RUN SHALL abort the operation; no partial result SHALL reach hi/lo after release.

Configuration
REQ-025 With macro MIPS_CPU_MULDIV_FAST_MULT_EN defined, MULT/MULTU SHALL compute the full 64-bit product in one cycle (start at E0 -> hi/lo written at E1 and done=1 in the following cycle, busy never high); DIV/DIVU are unchanged.
REQ-026 Without the macro, MULT/MULTU SHALL use the 32-iteration path of REQ-013..016.

Structure
REQ-027 Package mips_cpu_pkg SHALL hold the op encoding enum, FSM state enum, and constant MULDIV_ITER=32.
REQ-028 The single-iteration restoring-divide datapath SHALL be sub-module mips_cpu_div_step (combinational: remainder, quotient bit in; next remainder, quotient bit out).

Verification
REQ-029 MULTU a=0xFFFF_FFFF b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001, done at cycle 34 (or cycle 2 with FAST_MULT_EN).
REQ-030 MULT a=0xFFFF_FFFD (-3) b=5 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
REQ-031 DIV a=0xFFFF_FFF9 (-7) b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIVU a=100 b=7 -> lo=14, hi=2.
REQ-032 DIVU a=0x1234 b=0 -> hi=0x1234, lo=0xFFFF_FFFF after 34 cycles.
REQ-033 Start DIVU, pulse start with MTHI a=0xAAAA at cycle 10 -> MTHI ignored; result unchanged; then MTHI when idle -> hi=0xAAAA next edge, lo untouched.
REQ-034 Start DIV, assert reset=0 at cycle 15 for 1 cycle -> hi=lo=0, busy=0, no done pulse afterwards.
